// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: bus widths,
// mem_control_bus bit indices and encodings, the two-word opcode flag
// position and the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CTL_W  = 4;
    localparam int unsigned WAIT_W = 3;

    // mem_control_bus bit indices; bit 3 is reserved and always 0
    localparam int unsigned MEMCTL_LOAD_ADDR = 0;
    localparam int unsigned MEMCTL_WRITE     = 1;
    localparam int unsigned MEMCTL_READ      = 2;

    localparam logic [CTL_W-1:0] CTL_IDLE      = '0;
    localparam logic [CTL_W-1:0] CTL_LOAD_ADDR = CTL_W'(1) << MEMCTL_LOAD_ADDR;
    localparam logic [CTL_W-1:0] CTL_READ      = CTL_W'(1) << MEMCTL_READ;

    // Set in the first word when an operand word follows at address+1
    localparam int unsigned TWO_WORD_BIT = 15;

    typedef enum logic [2:0] {
        IF_IDLE  = 3'd0,
        IF_ADDR1 = 3'd1,
        IF_READ1 = 3'd2,
        IF_ADDR2 = 3'd3,
        IF_READ2 = 3'd4,
        IF_DONE  = 3'd5
    } if_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch request / shared-bus / result bundle of instruction_fetch.
//   master : requester side (P_reg update logic + resolved bus)
//   slave  : instruction_fetch itself
// With IFETCH_ABORT_EN defined the bundle also carries fetch_abort.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic              fetch_req;
    logic [WORD_W-1:0] P_reg;
    logic [WORD_W-1:0] bus_in;
    logic [WORD_W-1:0] bus_out;
    logic              bus_oe;
    logic [CTL_W-1:0]  mem_control_bus;
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] operand;
    logic              instr_valid;
    logic              double_increment;
    logic              busy;
`ifdef IFETCH_ABORT_EN
    logic              fetch_abort;

    modport master (
        output fetch_req, P_reg, bus_in, fetch_abort,
        input  bus_out, bus_oe, mem_control_bus, instruction, operand,
               instr_valid, double_increment, busy
    );
    modport slave (
        input  fetch_req, P_reg, bus_in, fetch_abort,
        output bus_out, bus_oe, mem_control_bus, instruction, operand,
               instr_valid, double_increment, busy
    );
`else
    modport master (
        output fetch_req, P_reg, bus_in,
        input  bus_out, bus_oe, mem_control_bus, instruction, operand,
               instr_valid, double_increment, busy
    );
    modport slave (
        input  fetch_req, P_reg, bus_in,
        output bus_out, bus_oe, mem_control_bus, instruction, operand,
               instr_valid, double_increment, busy
    );
`endif

endinterface

// File: rtl/instruction_fetch_wait_counter.sv
// Read-phase wait counter: loads READ_LATENCY on entry to a read phase,
// counts down once per read cycle and flags the last read cycle.
//   clock, reset : clock and synchronous active-high reset
//   load         : entering a read phase on this edge
//   dec          : currently in a read phase
//   clear        : abandon the count (fetch aborted)
//   last_c       : current cycle is the final read cycle
module instruction_fetch_wait_counter
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    input  logic clear,
    output logic last_c
);

    logic [WAIT_W-1:0] count;

    // Counts down to 0 on the final read edge, so it is idle-zero after every phase
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= WAIT_W'(READ_LATENCY);
        end else if (dec && (count != '0)) begin
            count <= count - WAIT_W'(1);
        end
    end

    assign last_c = (count == WAIT_W'(1));

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer in front of memory_controller. On an accepted
// fetch_req it drives P_reg onto the shared bus, runs the load-address and
// read phases on mem_control_bus, captures one or two words and reports
// them with a one-cycle instr_valid pulse (double_increment for two words).
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   fif (slave)  : fetch_req, P_reg, bus_in in; bus_out, bus_oe,
//                  mem_control_bus, instruction, operand, instr_valid,
//                  double_increment, busy out (all registered)
// Parameter READ_LATENCY (1..7): read-phase length in cycles.
// Optional IFETCH_ABORT_EN: adds fif.fetch_abort, which returns any busy
// fetch to IDLE on the next edge without publishing a result.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    instruction_fetch_if.slave  fif
);

    if_state_e         state;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] first_word;
    logic              abort_c;
    logic              wait_load_c;
    logic              wait_dec_c;
    logic              wait_last_c;

`ifdef IFETCH_ABORT_EN
    assign abort_c = fif.fetch_abort && (state != IF_IDLE);
`else
    assign abort_c = 1'b0;
`endif

    assign wait_load_c = !abort_c && ((state == IF_ADDR1) || (state == IF_ADDR2));
    assign wait_dec_c  = (state == IF_READ1) || (state == IF_READ2);

    instruction_fetch_wait_counter #(
        .READ_LATENCY (READ_LATENCY)
    ) u_wait (
        .clock  (clock),
        .reset  (reset),
        .load   (wait_load_c),
        .dec    (wait_dec_c),
        .clear  (abort_c),
        .last_c (wait_last_c)
    );

    // Fetch FSM; outputs are registered alongside the state they belong to.
    // Results are published only on entry to DONE so an abandoned fetch
    // never disturbs the previously reported instruction/operand.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IF_IDLE;
            addr                 <= '0;
            first_word           <= '0;
            fif.bus_out          <= '0;
            fif.bus_oe           <= 1'b0;
            fif.mem_control_bus  <= CTL_IDLE;
            fif.instruction      <= '0;
            fif.operand          <= '0;
            fif.instr_valid      <= 1'b0;
            fif.double_increment <= 1'b0;
            fif.busy             <= 1'b0;
        end else begin
            fif.bus_out          <= '0;
            fif.bus_oe           <= 1'b0;
            fif.mem_control_bus  <= CTL_IDLE;
            fif.instr_valid      <= 1'b0;
            fif.double_increment <= 1'b0;

            if (abort_c) begin
                state    <= IF_IDLE;
                fif.busy <= 1'b0;
            end else begin
                case (state)
                    IF_IDLE: begin
                        if (fif.fetch_req) begin
                            addr                <= fif.P_reg;
                            state               <= IF_ADDR1;
                            fif.busy            <= 1'b1;
                            fif.bus_oe          <= 1'b1;
                            fif.bus_out         <= fif.P_reg;
                            fif.mem_control_bus <= CTL_LOAD_ADDR;
                        end
                    end
                    IF_ADDR1: begin
                        state               <= IF_READ1;
                        fif.mem_control_bus <= CTL_READ;
                    end
                    IF_READ1: begin
                        if (!wait_last_c) begin
                            fif.mem_control_bus <= CTL_READ;
                        end else if (fif.bus_in[TWO_WORD_BIT]) begin
                            first_word          <= fif.bus_in;
                            state               <= IF_ADDR2;
                            fif.bus_oe          <= 1'b1;
                            fif.bus_out         <= addr + WORD_W'(1);
                            fif.mem_control_bus <= CTL_LOAD_ADDR;
                        end else begin
                            fif.instruction <= fif.bus_in;
                            fif.operand     <= '0;
                            fif.instr_valid <= 1'b1;
                            state           <= IF_DONE;
                        end
                    end
                    IF_ADDR2: begin
                        state               <= IF_READ2;
                        fif.mem_control_bus <= CTL_READ;
                    end
                    IF_READ2: begin
                        if (!wait_last_c) begin
                            fif.mem_control_bus <= CTL_READ;
                        end else begin
                            fif.instruction      <= first_word;
                            fif.operand          <= fif.bus_in;
                            fif.instr_valid      <= 1'b1;
                            fif.double_increment <= 1'b1;
                            state                <= IF_DONE;
                        end
                    end
                    default: begin
                        state    <= IF_IDLE;
                        fif.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
